aes_decipher_block: RTL and testbench
=====================================

Name: aes_decipher_block

Overview:
- Iterative AES inverse-cipher datapath; the decrypt counterpart of the encryption block.
- Consumes round keys from the shared key memory in descending order (Nr down to 0).
- Uses an external combinational inverse S-box one 32-bit word per cycle, mirroring the encryptor's shared-S-box scheme.
- Sits beside the encryptor under the top level; started by the key memory's ready.

Parameters:
None.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous active-low reset
- next  input  1  start pulse; accepted only while ready=1
- keylen  input  1  0=AES-128 (Nr=10), 1=AES-256 (Nr=14); sampled when next is accepted
- round  output  4  round-key index requested from key memory
- round_key  input  128  key for index `round`, valid combinationally in the same cycle
- inv_sboxw  output  32  word sent to the inverse S-box
- new_inv_sboxw  input  32  inverse-substituted word, combinational return
- block  input  128  ciphertext; sampled when next is accepted
- new_block  output  128  plaintext result register
- ready  output  1  1 = idle/result valid, 0 = busy

Behaviour:
- Word 0 = bits 127:96; byte/column order per FIPS-197.
- Reset (reset_n=0 at a clock edge, any state, including mid-operation):
  - FSM to IDLE; ready=1; new_block=0; internal state=0; round counter=0; stored keylen=0.
- FSM states:
  - IDLE:
    - round = keylen ? 14 : 10 (combinational from the port).
    - On next=1: state <= InvShiftRows(block ^ round_key); counter <= Nr-1; word index <= 0; ready <= 0; go SUB.
  - SUB (4 cycles, word index w=0..3):
    - inv_sboxw = state word w; state word w <= new_inv_sboxw.
    - After w=3, go ROUND.
  - ROUND (1 cycle):
    - If counter != 0: state <= InvShiftRows(InvMixColumns(state ^ round_key)); counter <= counter-1; go SUB.
    - If counter == 0: new_block <= state ^ round_key; ready <= 1; go IDLE.
- Outside IDLE, round = counter.
- Outside SUB, inv_sboxw = 32'h0.
- Latency: next accepted at edge k -> ready=1 and new_block valid at edge k+5*Nr.
  - AES-128: 50 cycles. AES-256: 70 cycles.
- new_block holds its value until the next completion or reset.
  - It is not cleared at start; it is stale while ready=0.
- next while ready=0: ignored; no restart, no effect.
- keylen or block changes while busy: no effect on the current operation.
- next asserted in the same cycle ready rises: not accepted (FSM still in ROUND). Accepted from the following cycle.
- next held high continuously: a new operation starts every 5*Nr+1 cycles, each using the block value at its acceptance edge.
- InvMixColumns: GF(2^8) multiplies by 0e,0b,0d,09, reduction polynomial 0x11b, purely combinational.

Optional Feature:
- Macro: AES_DEC_AES256_EN
- Defined: keylen honoured as above (Nr = 10 or 14).
- Not defined: keylen ignored; Nr fixed at 10; IDLE round = 10; the counter logic may be narrowed accordingly.
- Reset, handshake and AES-128 timing are identical in both builds.

Test Plan:
- Bench setup: a behavioural key-expansion model drives round_key from round; an inverse S-box table model drives new_inv_sboxw.
- Reset: hold reset_n=0 for 2 cycles -> ready=1, new_block=0, round=10 with keylen=0, inv_sboxw=0.
- AES-128 (FIPS-197 C.1):
  - key 000102030405060708090a0b0c0d0e0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, next pulse.
  - Expect: ready low next cycle; new_block=00112233445566778899aabbccddeeff with ready=1 exactly 50 cycles after acceptance.
  - Round sequence: 10, 9 (x5 cycles), ..., 0.
- AES-256 (FIPS-197 C.3, macro defined):
  - key 000102...1f, block 8ea2b7ca516745bfeafc49904b496089, keylen=1.
  - Expect new_block=00112233445566778899aabbccddeeff after 70 cycles; first round output=14.
- Busy-ignore: during the C.1 run, pulse next with block=0 at cycle 20 -> result still 00112233...eeff at cycle 50; no extra start.
- Mid-operation reset: reset_n=0 at cycle 30 of a C.1 run -> next edge ready=1, new_block=0, IDLE. A fresh C.1 run afterwards completes correctly.
- Back-to-back: next held high with two successive C.1 ciphertexts -> two correct results, starts 51 cycles apart. new_block holds the first result until the second completes.

Source files
------------

// File: rtl/aes_decipher_block.sv
// aes_decipher_block: iterative AES inverse-cipher datapath.
// One 32-bit word goes through the external inverse S-box per cycle, so each
// round takes 5 cycles: 4 SUB cycles, then 1 ROUND cycle.
// Optional AES-256 support is enabled with `define AES_DEC_AES256_EN.
// Without it, keylen is ignored and Nr is fixed at 10.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   next, keylen   start pulse (taken while ready=1) and key length
//   round          round-key index requested from the key memory
//   round_key      key for `round`, returned combinationally
//   inv_sboxw      word sent to the inverse S-box (zero outside SUB)
//   new_inv_sboxw  substituted word, returned combinationally
//   block          ciphertext, sampled when next is accepted
//   new_block      plaintext result register
//   ready          1 = idle / result valid
module aes_decipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  inv_sboxw,
  input  logic [31:0]  new_inv_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int unsigned BlockW = 128;
  localparam int unsigned WordW  = 32;
  localparam int unsigned RoundW = 4;
  localparam int unsigned WidxW  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUB   = 2'd1,
    ROUND = 2'd2
  } fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [BlockW-1:0]  state_q, state_d;
  logic [BlockW-1:0]  new_block_q, new_block_d;
  logic [RoundW-1:0]  cnt_q, cnt_d;
  logic [WidxW-1:0]   widx_q, widx_d;
  logic               ready_q, ready_d;
  logic [RoundW-1:0]  nr_c;

  // Number of rounds for the operation about to be started.
`ifdef AES_DEC_AES256_EN
  assign nr_c = keylen ? RoundW'(14) : RoundW'(10);
`else
  logic unused_keylen;
  assign unused_keylen = keylen;
  assign nr_c = RoundW'(10);
`endif

  // GF(2^8) multiply by 2, reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column (byte 0 in bits 31:24).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][c-r].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      new_block_q <= '0;
      cnt_q       <= '0;
      widx_q      <= '0;
      ready_q     <= 1'b1;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      new_block_q <= new_block_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic plus the combinational key-index and S-box outputs.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    new_block_d = new_block_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    ready_d     = ready_q;
    round       = cnt_q;
    inv_sboxw   = '0;

    unique case (fsm_q)
      IDLE: begin
        round = nr_c;
        if (next) begin
          state_d = inv_shift_rows(block ^ round_key);
          cnt_d   = nr_c - RoundW'(1);
          widx_d  = '0;
          ready_d = 1'b0;
          fsm_d   = SUB;
        end
      end
      SUB: begin
        unique case (widx_q)
          2'd0: begin
            inv_sboxw         = state_q[127:96];
            state_d[127:96]   = new_inv_sboxw;
          end
          2'd1: begin
            inv_sboxw         = state_q[95:64];
            state_d[95:64]    = new_inv_sboxw;
          end
          2'd2: begin
            inv_sboxw         = state_q[63:32];
            state_d[63:32]    = new_inv_sboxw;
          end
          default: begin
            inv_sboxw         = state_q[WordW-1:0];
            state_d[WordW-1:0] = new_inv_sboxw;
          end
        endcase
        widx_d = widx_q + WidxW'(1);
        if (widx_q == WidxW'(3)) begin
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q != '0) begin
          state_d = inv_shift_rows(inv_mix_columns(state_q ^ round_key));
          cnt_d   = cnt_q - RoundW'(1);
          fsm_d   = SUB;
        end else begin
          new_block_d = state_q ^ round_key;
          ready_d     = 1'b1;
          fsm_d       = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign new_block = new_block_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// tb_aes_decipher_block: bench for aes_decipher_block with a key-memory model,
// an inverse S-box table, and a textbook inverse-cipher reference model.
module tb_aes_decipher_block;

`ifdef AES_DEC_AES256_EN
  localparam bit Has256 = 1'b1;
`else
  localparam bit Has256 = 1'b0;
`endif

  localparam logic [255:0] Key128 =
    256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] Key256 =
    256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] Ct128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Pt    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct2   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  inv_sboxw;
  logic [31:0]  new_inv_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [7:0]   sbox  [0:255];
  logic [7:0]   isbox [0:255];
  logic [127:0] rk_mem [0:15];

  int n_chk  = 0;
  int n_pass = 0;

  aes_decipher_block dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .next          (next),
    .keylen        (keylen),
    .round         (round),
    .round_key     (round_key),
    .inv_sboxw     (inv_sboxw),
    .new_inv_sboxw (new_inv_sboxw),
    .block         (block),
    .new_block     (new_block),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  assign round_key     = rk_mem[round];
  assign new_inv_sboxw = {isbox[inv_sboxw[31:24]], isbox[inv_sboxw[23:16]],
                          isbox[inv_sboxw[15:8]],  isbox[inv_sboxw[7:0]]};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  // S-box from the GF(2^8) inverse and affine map; inverse table by inversion.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  // FIPS-197 key expansion into the key memory model.
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [64];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk_mem[r] = '0;
    end
  endtask

  // Textbook inverse cipher; returns {pre-InvSubBytes state of each round, plaintext}.
  function automatic logic [15*128-1:0] ref_run(input logic [127:0] ct, input int nr);
    logic [15*128-1:0] res;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    res = '0;
    v = ct ^ rk_mem[nr];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*((c+w)%4)+w] = s[4*c+w];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      res[15*128-1-128*(nr-1-r) -: 128] = v;
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = isbox[t[i]];
      v = v ^ rk_mem[r];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++)
            t[4*c+w] = gmul(8'h0e, s[4*c+w])         ^ gmul(8'h0b, s[4*c+(w+1)%4]) ^
                       gmul(8'h0d, s[4*c+(w+2)%4])   ^ gmul(8'h09, s[4*c+(w+3)%4]);
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      end
    end
    res[127:0] = v;
    return res;
  endfunction

  // Transaction-level model: acceptance, 5*Nr busy cycles, result.
  bit           m_busy  = 1'b0;
  logic         m_ready = 1'b1;
  int           m_j     = 0;
  int           m_nr    = 10;
  logic [127:0] m_nb    = '0;
  logic [127:0] m_pt    = '0;
  logic [127:0] m_pre [0:13];
  logic [15*128-1:0] m_res;
  bit           chk_en  = 1'b0;

  always begin
    @(posedge clk);
    if (!reset_n) begin
      m_busy = 1'b0; m_ready = 1'b1; m_nb = '0; m_j = 0;
    end else if (m_busy) begin
      m_j = m_j + 1;
      if (m_j == 5 * m_nr) begin
        m_busy = 1'b0; m_ready = 1'b1; m_nb = m_pt;
      end
    end else if (next) begin
      m_nr  = (Has256 && keylen) ? 14 : 10;
      m_res = ref_run(block, m_nr);
      for (int i = 0; i < 14; i++) m_pre[i] = m_res[15*128-1-128*i -: 128];
      m_pt    = m_res[127:0];
      m_busy  = 1'b1;
      m_j     = 0;
      m_ready = 1'b0;
    end
  end

  int          c_idx, c_ph;
  logic [3:0]  exp_round;
  logic [31:0] exp_sb;

  // Per-cycle comparison of all outputs against the model.
  always begin
    @(negedge clk);
    if (chk_en) begin
      if (m_busy) begin
        c_idx     = m_j / 5;
        c_ph      = m_j % 5;
        exp_round = 4'(m_nr - 1 - c_idx);
        exp_sb    = (c_ph < 4) ? m_pre[c_idx][127-32*c_ph -: 32] : 32'h0;
      end else begin
        exp_round = (Has256 && keylen) ? 4'd14 : 4'd10;
        exp_sb    = 32'h0;
      end
      chk("cyc_ready",     128'(ready),     128'(m_ready));
      chk("cyc_round",     128'(round),     128'(exp_round));
      chk("cyc_inv_sboxw", 128'(inv_sboxw), 128'(exp_sb));
      chk("cyc_new_block", new_block,       m_nb);
    end
  end

  task automatic start(input logic [127:0] ct, input logic kl);
    block = ct; keylen = kl; next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ready && cyc < limit);
  endtask

  int cyc, cyc2;
  logic [15*128-1:0] tmp_res;
  logic [127:0] pt2;

  initial begin
    reset_n = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    build_sbox();

    // Pin the reference tables and the model against FIPS-197 values.
    chk("sbox_00",   128'(sbox[8'h00]),  128'(8'h63));
    chk("sbox_53",   128'(sbox[8'h53]),  128'(8'hed));
    chk("isbox_63",  128'(isbox[8'h63]), 128'(8'h00));
    chk("gmul_5783", 128'(gmul(8'h57, 8'h83)), 128'(8'hc1));
    expand(Key128, 4);
    chk("rk10_c1", rk_mem[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    tmp_res = ref_run(Ct128, 10);
    chk("model_pt_c1", tmp_res[127:0], Pt);

    // Reset held for two edges.
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready",     128'(ready),     128'(1'b1));
    chk("rst_new_block", new_block,       128'h0);
    chk("rst_round",     128'(round),     128'(4'd10));
    chk("rst_inv_sboxw", 128'(inv_sboxw), 128'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // AES-128 FIPS-197 C.1.
    chk("c1_idle_round", 128'(round), 128'(4'd10));
    start(Ct128, 1'b0);
    chk("c1_busy",        128'(ready), 128'(1'b0));
    chk("c1_first_round", 128'(round), 128'(4'd9));
    wait_done(200, cyc);
    chk("c1_latency", 128'(cyc), 128'(50));
    chk("c1_result",  new_block, Pt);
    chk("c1_ready",   128'(ready), 128'(1'b1));

`ifdef AES_DEC_AES256_EN
    // AES-256 FIPS-197 C.3.
    expand(Key256, 8);
    keylen = 1'b1; #1;
    chk("c3_idle_round", 128'(round), 128'(4'd14));
    start(Ct256, 1'b1);
    wait_done(200, cyc);
    chk("c3_latency", 128'(cyc), 128'(70));
    chk("c3_result",  new_block, Pt);
    expand(Key128, 4);
    keylen = 1'b0;
`else
    // keylen has no effect in the AES-128-only build.
    keylen = 1'b1; #1;
    chk("kl_idle_round", 128'(round), 128'(4'd10));
    start(Ct128, 1'b1);
    wait_done(200, cyc);
    chk("kl_latency", 128'(cyc), 128'(50));
    chk("kl_result",  new_block, Pt);
    keylen = 1'b0;
`endif
    @(posedge clk); #1;

    // next pulsed while busy is ignored.
    start(Ct128, 1'b0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 19) begin next = 1'b1; block = '0; end
      else if (cyc == 20) next = 1'b0;
    end while (!ready && cyc < 200);
    chk("busy_latency", 128'(cyc), 128'(50));
    chk("busy_result",  new_block, Pt);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_no_restart", 128'(ready), 128'(1'b1));

    // Reset in the middle of an operation, then a fresh run.
    start(Ct128, 1'b0);
    repeat (29) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready",     128'(ready), 128'(1'b1));
    chk("mid_rst_new_block", new_block,   128'h0);
    chk("mid_rst_round",     128'(round), 128'(4'd10));
    reset_n = 1'b1;
    @(posedge clk); #1;
    start(Ct128, 1'b0);
    wait_done(200, cyc);
    chk("post_rst_latency", 128'(cyc), 128'(50));
    chk("post_rst_result",  new_block, Pt);

    // next held high: back-to-back operations.
    tmp_res = ref_run(Ct2, 10);
    pt2 = tmp_res[127:0];
    block = Ct128; keylen = 1'b0; next = 1'b1;
    @(posedge clk); #1;
    block = Ct2;
    chk("b2b_busy1", 128'(ready), 128'(1'b0));
    wait_done(200, cyc);
    chk("b2b_result1", new_block, Pt);
    @(posedge clk); #1;
    chk("b2b_start_gap", 128'(cyc + 1), 128'(51));
    chk("b2b_busy2",     128'(ready),   128'(1'b0));
    repeat (25) @(posedge clk);
    #1;
    chk("b2b_hold", new_block, Pt);
    wait_done(200, cyc2);
    next = 1'b0;
    chk("b2b_latency2", 128'(cyc2), 128'(25));
    chk("b2b_result2",  new_block, pt2);
    @(posedge clk); #1;
    chk("b2b_idle", 128'(ready), 128'(1'b1));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
